// File: rtl/prime_div3_tally.sv
// prime_div3_tally: windowed counts, sum, max prime and longest prime run over
// WINDOW accepted samples, reported as one valid/ready result frame.
module prime_div3_tally #(
   parameter int WINDOW = 8,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_a,
   input  logic               in_p,
   input  logic               in_d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   out_prime_cnt,
   output logic [CNT_W-1:0]   out_div3_cnt,
   output logic [CNT_W-1:0]   out_both_cnt,
   output logic [CNT_W+3:0]   out_sum,
   output logic [3:0]         out_max_prime,
   output logic [CNT_W-1:0]   out_max_run
);
   localparam logic [0:0] ACCUM  = 1'b0;
   localparam logic [0:0] REPORT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] smp_q, smp_d, prime_q, prime_d, div3_q, div3_d, both_q, both_d;
   logic [CNT_W-1:0] cur_q, cur_d, run_q, run_d;
   logic [CNT_W+3:0] sum_q, sum_d;
   logic [3:0]       maxp_q, maxp_d;
   logic [CNT_W-1:0] oprime_q, oprime_d, odiv3_q, odiv3_d, oboth_q, oboth_d, orun_q, orun_d;
   logic [CNT_W+3:0] osum_q, osum_d;
   logic [3:0]       omaxp_q, omaxp_d;

   logic             accept, last;
   logic [CNT_W-1:0] prime_inc, div3_inc, both_inc, cur_inc, run_inc;
   logic [CNT_W+3:0] sum_inc;
   logic [3:0]       maxp_inc;

   assign in_ready      = (state_q == ACCUM);
   assign out_valid     = (state_q == REPORT);
   assign out_prime_cnt = oprime_q;
   assign out_div3_cnt  = odiv3_q;
   assign out_both_cnt  = oboth_q;
   assign out_sum       = osum_q;
   assign out_max_prime = omaxp_q;
   assign out_max_run   = orun_q;

   // Accumulator values including the current sample, used both for normal
   // accumulation and for latching the final sample of a window.
   always_comb begin
      accept    = in_valid && in_ready;
      last      = accept && (smp_q == CNT_W'(WINDOW - 1));
      prime_inc = prime_q + CNT_W'(in_p);
      div3_inc  = div3_q + CNT_W'(in_d);
      both_inc  = both_q + CNT_W'(in_p && in_d);
      sum_inc   = sum_q + (CNT_W+4)'(in_a);
      maxp_inc  = (in_p && in_a > maxp_q) ? in_a : maxp_q;
      cur_inc   = in_p ? cur_q + 1'b1 : '0;
      run_inc   = (cur_inc > run_q) ? cur_inc : run_q;
   end

   always_comb begin
      state_d  = state_q;
      smp_d    = smp_q;
      prime_d  = prime_q;
      div3_d   = div3_q;
      both_d   = both_q;
      sum_d    = sum_q;
      maxp_d   = maxp_q;
      cur_d    = cur_q;
      run_d    = run_q;
      oprime_d = oprime_q;
      odiv3_d  = odiv3_q;
      oboth_d  = oboth_q;
      osum_d   = osum_q;
      omaxp_d  = omaxp_q;
      orun_d   = orun_q;
      if (clear || last) begin
         smp_d   = '0;
         prime_d = '0;
         div3_d  = '0;
         both_d  = '0;
         sum_d   = '0;
         maxp_d  = '0;
         cur_d   = '0;
         run_d   = '0;
      end
      if (clear) begin
         state_d = ACCUM;
      end else if (last) begin
         state_d  = REPORT;
         oprime_d = prime_inc;
         odiv3_d  = div3_inc;
         oboth_d  = both_inc;
         osum_d   = sum_inc;
         omaxp_d  = maxp_inc;
         orun_d   = run_inc;
      end else if (accept) begin
         smp_d   = smp_q + 1'b1;
         prime_d = prime_inc;
         div3_d  = div3_inc;
         both_d  = both_inc;
         sum_d   = sum_inc;
         maxp_d  = maxp_inc;
         cur_d   = cur_inc;
         run_d   = run_inc;
      end else if (out_valid && out_ready) begin
         state_d = ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ACCUM;
         smp_q    <= '0;
         prime_q  <= '0;
         div3_q   <= '0;
         both_q   <= '0;
         sum_q    <= '0;
         maxp_q   <= '0;
         cur_q    <= '0;
         run_q    <= '0;
         oprime_q <= '0;
         odiv3_q  <= '0;
         oboth_q  <= '0;
         osum_q   <= '0;
         omaxp_q  <= '0;
         orun_q   <= '0;
      end else begin
         state_q  <= state_d;
         smp_q    <= smp_d;
         prime_q  <= prime_d;
         div3_q   <= div3_d;
         both_q   <= both_d;
         sum_q    <= sum_d;
         maxp_q   <= maxp_d;
         cur_q    <= cur_d;
         run_q    <= run_d;
         oprime_q <= oprime_d;
         odiv3_q  <= odiv3_d;
         oboth_q  <= oboth_d;
         osum_q   <= osum_d;
         omaxp_q  <= omaxp_d;
         orun_q   <= orun_d;
      end
   end
endmodule

// File: tb/tb_prime_div3_tally.sv
// tb_prime_div3_tally: directed window vectors plus back-pressure, clear and
// mid-frame reset sequences for prime_div3_tally with WINDOW=4.
module tb_prime_div3_tally;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_a = '0;
   logic        in_p = 1'b0;
   logic        in_d = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_prime_cnt, out_div3_cnt, out_both_cnt, out_max_run;
   logic [11:0] out_sum;
   logic [3:0]  out_max_prime;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] a;
      logic [3:0]  p;
      logic [3:0]  d;
      logic        bub;
      logic [7:0]  pc, dc, bc;
      logic [11:0] sum;
      logic [3:0]  mp;
      logic [7:0]  run;
   } vec_t;

   vec_t vt[5];

   prime_div3_tally #(.WINDOW(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_p(in_p), .in_d(in_d),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prime_cnt(out_prime_cnt), .out_div3_cnt(out_div3_cnt),
      .out_both_cnt(out_both_cnt), .out_sum(out_sum),
      .out_max_prime(out_max_prime), .out_max_run(out_max_run)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_fields(input vec_t v);
      chk("prime_cnt", 32'(out_prime_cnt), 32'(v.pc));
      chk("div3_cnt", 32'(out_div3_cnt), 32'(v.dc));
      chk("both_cnt", 32'(out_both_cnt), 32'(v.bc));
      chk("sum", 32'(out_sum), 32'(v.sum));
      chk("max_prime", 32'(out_max_prime), 32'(v.mp));
      chk("max_run", 32'(out_max_run), 32'(v.run));
   endtask

   // Presents one sample, waits (bounded) for in_ready, returns #1 after the accepting edge.
   task automatic send(input logic [3:0] a, input logic p, input logic d);
      int t = 0;
      in_valid = 1'b1; in_a = a; in_p = p; in_d = d;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         n_vec++; n_bad++;
         $display("FAIL send_timeout: in_ready stuck at 0");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         if (v.bub) begin
            @(posedge clk); #1;
         end
         send(v.a[4*i +: 4], v.p[i], v.d[i]);
         chk($sformatf("out_valid_after_%0d", i), 32'(out_valid), 32'(i == 3));
      end
      chk_fields(v);
   endtask

   task automatic release_frame();
      @(posedge clk); #1;
      chk("valid_after_hs", 32'(out_valid), 0);
      chk("ready_after_hs", 32'(in_ready), 1);
   endtask

   initial begin
      vec_t bp;
      vec_t cl;
      vec_t zero;
      vt[0] = '{16'h9432, 4'b0011, 4'b1010, 1'b0, 8'd2, 8'd2, 8'd1, 12'd18, 4'd3,  8'd2};
      vt[1] = '{16'hDB75, 4'b1111, 4'b0000, 1'b1, 8'd4, 8'd0, 8'd0, 12'd36, 4'd13, 8'd4};
      vt[2] = '{16'h8640, 4'b0000, 4'b0101, 1'b0, 8'd0, 8'd2, 8'd0, 12'd18, 4'd0,  8'd0};
      vt[3] = '{16'h7453, 4'b1011, 4'b0001, 1'b0, 8'd3, 8'd1, 8'd1, 12'd19, 4'd7,  8'd2};
      vt[4] = '{16'h321D, 4'b1101, 4'b1000, 1'b1, 8'd3, 8'd1, 8'd1, 12'd19, 4'd13, 8'd2};
      bp    = '{16'h0005, 4'b0001, 4'b1110, 1'b0, 8'd1, 8'd3, 8'd0, 12'd5,  4'd5,  8'd1};
      cl    = '{16'hFFFF, 4'b0000, 4'b1111, 1'b0, 8'd0, 8'd4, 8'd0, 12'd60, 4'd0,  8'd0};
      zero  = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 8'd0, 8'd0, 8'd0, 12'd0,  4'd0,  8'd0};

      #1;
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_ready", 32'(in_ready), 1);
      chk_fields(zero);
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (vt[k]) begin
         apply(vt[k]);
         release_frame();
      end

      // Back-pressure: frame held, upstream sample waits and lands in the next window.
      out_ready = 1'b0;
      apply(vt[0]);
      in_valid = 1'b1; in_a = 4'd5; in_p = 1'b1; in_d = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ready", 32'(in_ready), 0);
         chk("bp_sum_hold", 32'(out_sum), 32'd18);
         chk("bp_run_hold", 32'(out_max_run), 32'd2);
      end
      out_ready = 1'b1;
      release_frame();
      apply(bp);
      release_frame();

      // Clear mid-window, with a sample offered in the same cycle.
      send(4'd7, 1'b1, 1'b0);
      send(4'd7, 1'b1, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_a = 4'd3; in_p = 1'b1; in_d = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("clear_valid", 32'(out_valid), 0);
      chk("clear_ready", 32'(in_ready), 1);
      apply(cl);
      release_frame();

      // Asynchronous reset while a frame is pending.
      out_ready = 1'b0;
      apply(vt[1]);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk_fields(zero);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      apply(vt[2]);
      release_frame();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
